cs_microsequencer: RTL
======================

// Module: cs_microsequencer
// PURPOSE
//  Next-address sequencer for the microprogrammed control unit. Each cycle it selects the control-store
//  ROM address from the current microword's COND/ADDRESS fields, the PSR flags and the IR, and drives
//  the MIR load enable. It stalls the microprogram while a microword's RD/WR memory access waits for
//  acknowledge, and enters a sticky fault on memory timeout or on an illegal RD&WR microword.
// PARAMETERS
//  SEQ_LENGTH_ADDR  11  control-store address width (ROM depth 2**11)
//  SEQ_LENGTH_COND   3  COND field width
//  SEQ_MEM_TIMEOUT   8  max consecutive un-acked memory cycles before FAULT (>=2)
// PORTS
//  CS_SEQ_CLOCK_50              in   1   system clock, all state on rising edge
//  CS_SEQ_RESET_InHigh          in   1   asynchronous, active-high reset
//  CS_SEQ_COND_data_InBUS       in   3   MIR COND field
//  CS_SEQ_ADDRESS_data_InBUS    in   11  MIR jump-address field
//  CS_SEQ_RD_data_In            in   1   MIR RD bit
//  CS_SEQ_WR_data_In            in   1   MIR WR bit
//  CS_SEQ_FLAGS_data_InBUS      in   4   PSR flags {n,z,v,c}
//  CS_SEQ_IR13_data_In          in   1   IR[13] (immediate select)
//  CS_SEQ_IROP_data_InBUS       in   8   {IR[31:30], IR[24:19]}
//  CS_SEQ_MEM_ACK_In            in   1   memory access complete, valid this cycle
//  CS_SEQ_ROM_ADDRESS_data_OutBUS out 11 control-store ROM address (ROM read combinational)
//  CS_SEQ_MIR_load_OutLow       out  1   0 = MIR captures ROM output on this edge
//  CS_SEQ_STALL_Out             out  1   microprogram held this cycle
//  CS_SEQ_TIMEOUT_Out           out  1   sticky fault flag
// BEHAVIOUR
//  - Reset (async, any state): state=BOOT, CSAR=0, wait counter=0, fault=0. Outputs while reset held:
//    ROM_ADDRESS=0, MIR_load_OutLow=0, STALL=0, TIMEOUT=0.
//  - CSAR register = address of the microword currently held in the MIR.
//  - Next address (combinational, SEQ_LENGTH_ADDR bits, incrementer wraps 0x7FF->0x000):
//    000 CSAR+1 | 001 n?ADDR:CSAR+1 | 010 z?.. | 011 v?.. | 100 c?.. | 101 IR13?ADDR:CSAR+1
//    110 ADDR unconditional | 111 decode {1'b1, IROP[7:6], IROP[5:0], 2'b00}.
//    Flags/IR are sampled in the advancing cycle.
//  - advance = state RUN and (no RD/WR, or ACK=1), or state MEM_WAIT and ACK=1.
//    On advance: ROM_ADDRESS=next, load_OutLow=0, CSAR<=next at the edge (latency 1 cycle/microword).
//    Otherwise: ROM_ADDRESS=CSAR, load_OutLow=1, STALL=1.
//  - FSM:
//    BOOT: ROM_ADDRESS=0, load_OutLow=0, STALL=0, CSAR<=0 -> RUN.
//    RUN: RD&WR both 1 -> FAULT (no advance). RD|WR with ACK=0 -> MEM_WAIT, cnt<=1.
//      Otherwise advance, stay RUN.
//    MEM_WAIT: ACK=1 -> advance, cnt<=0 -> RUN (ACK wins over timeout in the same cycle).
//      ACK=0 and cnt==SEQ_MEM_TIMEOUT-1 -> FAULT. Otherwise cnt<=cnt+1.
//    FAULT: STALL=1, load_OutLow=1, TIMEOUT=1, ROM_ADDRESS=CSAR; exits only via reset.
//  - STALL therefore spans exactly SEQ_MEM_TIMEOUT cycles before FAULT; ACK outside a memory
//    microword is ignored.
//  - Counter width $clog2(SEQ_MEM_TIMEOUT+1); no other arithmetic beyond the wrapping incrementer.
// STRUCTURE
//  - Package cs_seq_pkg: COND encodings (COND_NEXT..COND_DECODE), state encoding
//    (BOOT/RUN/MEM_WAIT/FAULT), decode-address constant prefix.
//  - Sub-module cs_seq_next_addr: purely combinational COND/flag/decode mux + incrementer.
//  - Top: FSM, CSAR, wait counter, output muxing.
// TESTING
//  - Reset release: cycle 1 ROM_ADDRESS=0x000, load_OutLow=0. With MIR COND=000 next cycle:
//    ROM_ADDRESS=0x001, STALL=0.
//  - CSAR=0x010, COND=010, ADDR=0x123: z=1 -> 0x123; z=0 -> 0x011. Repeat for n,v,c,IR13 and COND=110.
//  - COND=111, IROP={2'b10,6'b010000} -> ROM_ADDRESS=0x640. CSAR=0x7FF, COND=000 -> 0x000.
//  - RD=1, ACK low 3 cycles then high: STALL=1 and ROM_ADDRESS=CSAR, load_OutLow=1 for 3 cycles;
//    advance on the 4th cycle. Also cover ACK=1 on the first cycle (no stall).
//  - RD=1, ACK never: STALL held 8 cycles, then TIMEOUT=1 sticky; ACK on 8th cycle -> no fault.
//    RD=WR=1 -> FAULT next cycle.
//  - Async reset asserted in MEM_WAIT and FAULT: outputs return to reset values immediately;
//    BOOT sequence repeats.

Source files
------------

// File: rtl/cs_microsequencer_pkg.sv
// Shared encodings for the control-store microsequencer: COND field values,
// sequencer FSM states and the opcode-decode address prefix.
package cs_seq_pkg;

   typedef enum logic [2:0] {
      COND_NEXT   = 3'b000,
      COND_N      = 3'b001,
      COND_Z      = 3'b010,
      COND_V      = 3'b011,
      COND_C      = 3'b100,
      COND_IR13   = 3'b101,
      COND_JUMP   = 3'b110,
      COND_DECODE = 3'b111
   } cond_e;

   typedef enum logic [1:0] {
      BOOT     = 2'b00,
      RUN      = 2'b01,
      MEM_WAIT = 2'b10,
      FAULT    = 2'b11
   } seqState_e;

   // Decode targets live in the upper half of the control store, 4 words per opcode.
   localparam logic DECODE_PREFIX = 1'b1;

endpackage

// File: rtl/cs_microsequencer_next_addr.sv
// Combinational next-address selection: COND/flag/IR mux, opcode decode and
// a wrapping CSAR incrementer.
module cs_seq_next_addr
   import cs_seq_pkg::*;
#(
   parameter int SEQ_LENGTH_ADDR = 11,
   parameter int SEQ_LENGTH_COND = 3
)(
   input  logic [SEQ_LENGTH_COND-1:0] condField,
   input  logic [SEQ_LENGTH_ADDR-1:0] jumpAddr,
   input  logic [SEQ_LENGTH_ADDR-1:0] csar,
   input  logic [3:0]                 flags,
   input  logic                       ir13,
   input  logic [7:0]                 irOp,
   output logic [SEQ_LENGTH_ADDR-1:0] nextAddr
);

   logic [SEQ_LENGTH_ADDR-1:0] incAddr;
   logic [SEQ_LENGTH_ADDR-1:0] decodeAddr;

   assign incAddr    = csar + SEQ_LENGTH_ADDR'(1);
   assign decodeAddr = SEQ_LENGTH_ADDR'({DECODE_PREFIX, irOp[7:6], irOp[5:0], 2'b00});

   always_comb begin
      nextAddr = incAddr;
      case (cond_e'(condField))
         COND_NEXT:   nextAddr = incAddr;
         COND_N:      nextAddr = flags[3] ? jumpAddr : incAddr;
         COND_Z:      nextAddr = flags[2] ? jumpAddr : incAddr;
         COND_V:      nextAddr = flags[1] ? jumpAddr : incAddr;
         COND_C:      nextAddr = flags[0] ? jumpAddr : incAddr;
         COND_IR13:   nextAddr = ir13     ? jumpAddr : incAddr;
         COND_JUMP:   nextAddr = jumpAddr;
         COND_DECODE: nextAddr = decodeAddr;
         default:     nextAddr = incAddr;
      endcase
   end

endmodule

// File: rtl/cs_microsequencer.sv
// Microsequencer top: boot/run/memory-wait/fault FSM, CSAR, memory wait
// counter and ROM address / MIR load output muxing.
module cs_microsequencer
   import cs_seq_pkg::*;
#(
   parameter int SEQ_LENGTH_ADDR = 11,
   parameter int SEQ_LENGTH_COND = 3,
   parameter int SEQ_MEM_TIMEOUT = 8
)(
   input  logic                       CS_SEQ_CLOCK_50,
   input  logic                       CS_SEQ_RESET_InHigh,
   input  logic [SEQ_LENGTH_COND-1:0] CS_SEQ_COND_data_InBUS,
   input  logic [SEQ_LENGTH_ADDR-1:0] CS_SEQ_ADDRESS_data_InBUS,
   input  logic                       CS_SEQ_RD_data_In,
   input  logic                       CS_SEQ_WR_data_In,
   input  logic [3:0]                 CS_SEQ_FLAGS_data_InBUS,
   input  logic                       CS_SEQ_IR13_data_In,
   input  logic [7:0]                 CS_SEQ_IROP_data_InBUS,
   input  logic                       CS_SEQ_MEM_ACK_In,
   output logic [SEQ_LENGTH_ADDR-1:0] CS_SEQ_ROM_ADDRESS_data_OutBUS,
   output logic                       CS_SEQ_MIR_load_OutLow,
   output logic                       CS_SEQ_STALL_Out,
   output logic                       CS_SEQ_TIMEOUT_Out
);

   localparam int CNT_W = $clog2(SEQ_MEM_TIMEOUT + 1);

   seqState_e                  state;
   logic [SEQ_LENGTH_ADDR-1:0] csar;
   logic [SEQ_LENGTH_ADDR-1:0] nextAddr;
   logic [CNT_W-1:0]           waitCnt;
   logic                       memReq;
   logic                       illegalRw;
   logic                       advance;

   cs_seq_next_addr #(
      .SEQ_LENGTH_ADDR (SEQ_LENGTH_ADDR),
      .SEQ_LENGTH_COND (SEQ_LENGTH_COND)
   ) uNextAddr (
      .condField (CS_SEQ_COND_data_InBUS),
      .jumpAddr  (CS_SEQ_ADDRESS_data_InBUS),
      .csar      (csar),
      .flags     (CS_SEQ_FLAGS_data_InBUS),
      .ir13      (CS_SEQ_IR13_data_In),
      .irOp      (CS_SEQ_IROP_data_InBUS),
      .nextAddr  (nextAddr)
   );

   assign memReq    = CS_SEQ_RD_data_In | CS_SEQ_WR_data_In;
   assign illegalRw = CS_SEQ_RD_data_In & CS_SEQ_WR_data_In;
   // An RD&WR microword never advances, even with ACK high.
   assign advance   = ((state == RUN) && !illegalRw && (!memReq || CS_SEQ_MEM_ACK_In)) ||
                      ((state == MEM_WAIT) && CS_SEQ_MEM_ACK_In);

   always_ff @(posedge CS_SEQ_CLOCK_50 or posedge CS_SEQ_RESET_InHigh) begin
      if (CS_SEQ_RESET_InHigh) begin
         state   <= BOOT;
         csar    <= '0;
         waitCnt <= '0;
      end else begin
         case (state)
            BOOT: begin
               csar    <= '0;
               waitCnt <= '0;
               state   <= RUN;
            end
            RUN: begin
               if (illegalRw) begin
                  state <= FAULT;
               end else if (memReq && !CS_SEQ_MEM_ACK_In) begin
                  waitCnt <= CNT_W'(1);
                  state   <= MEM_WAIT;
               end else begin
                  csar <= nextAddr;
               end
            end
            MEM_WAIT: begin
               if (CS_SEQ_MEM_ACK_In) begin
                  csar    <= nextAddr;
                  waitCnt <= '0;
                  state   <= RUN;
               end else if (waitCnt == CNT_W'(SEQ_MEM_TIMEOUT - 1)) begin
                  state <= FAULT;
               end else begin
                  waitCnt <= waitCnt + CNT_W'(1);
               end
            end
            default: state <= FAULT;
         endcase
      end
   end

   always_comb begin
      CS_SEQ_ROM_ADDRESS_data_OutBUS = csar;
      CS_SEQ_MIR_load_OutLow         = 1'b1;
      CS_SEQ_STALL_Out               = 1'b1;
      if (state == BOOT) begin
         CS_SEQ_ROM_ADDRESS_data_OutBUS = '0;
         CS_SEQ_MIR_load_OutLow         = 1'b0;
         CS_SEQ_STALL_Out               = 1'b0;
      end else if (advance) begin
         CS_SEQ_ROM_ADDRESS_data_OutBUS = nextAddr;
         CS_SEQ_MIR_load_OutLow         = 1'b0;
         CS_SEQ_STALL_Out               = 1'b0;
      end
   end

   assign CS_SEQ_TIMEOUT_Out = (state == FAULT);

endmodule
